// File: rtl/ahb_mem_responder.sv
// ahb_mem_responder: AHB-lite memory slave with a 64-bit array, programmable wait states
// and a two-cycle ERROR response for out-of-range or misaligned accesses.
module ahb_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        HTRANS,
    input  logic [63:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HSIZE,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [63:0] LIMIT   = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  WC_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t        r_state, w_next, w_target;
    logic [63:0]   r_mem [DEPTH];
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [2:0]    r_lane;
    logic [1:0]    r_size;
    logic          r_write;
    logic [63:0]   w_off;
    logic [2:0]    w_amask;
    logic [7:0]    w_bmask;
    logic          w_err, w_accept;

    assign w_off     = HADDR - BASE_ADDR;
    assign w_amask   = 3'((4'd1 << HSIZE) - 4'd1);
    assign w_err     = (HADDR < BASE_ADDR) || (w_off >= LIMIT) || ((w_off[2:0] & w_amask) != 3'd0);
    assign w_accept  = HTRANS && HREADYOUT;
    assign w_target  = w_err ? S_ERR1 : ((WAIT_CYCLES > 0) ? S_WAIT : S_DATA);
    // (1 << bytes) - 1 gives the lane run for the access size, shifted up to its starting lane
    assign w_bmask   = 8'(((16'd1 << (5'd1 << r_size)) - 16'd1) << r_lane);

    assign HREADYOUT = !(r_state == S_WAIT || r_state == S_ERR1);
    assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
    assign HRDATA    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : 64'd0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DATA, S_ERR2: w_next = w_accept ? w_target : S_IDLE;
            S_WAIT:                 w_next = (r_cnt == 4'd0) ? S_DATA : S_WAIT;
            S_ERR1:                 w_next = S_ERR2;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_lane  <= 3'd0;
            r_size  <= 2'd0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_off[3 +: AW];
                r_lane  <= w_off[2:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
                r_cnt   <= WC_INIT;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Array has no reset; reset forces IDLE so a pending write can never commit
    always_ff @(posedge CLK) begin
        if (r_state == S_DATA && r_write)
            for (int b = 0; b < 8; b++)
                if (w_bmask[b]) r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
    end
endmodule

// File: tb/tb_ahb_mem_responder.sv
// tb_ahb_mem_responder: directed checks of a zero-wait and a three-wait responder instance.
module tb_ahb_mem_responder;
    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        htrans0, hwrite0, htrans3, hwrite3;
    logic [1:0]  hsize0, hsize3;
    logic [63:0] haddr0, hwdata0, haddr3, hwdata3;
    logic [63:0] hrdata0, hrdata3;
    logic        hready0, hresp0, hready3, hresp3;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    ahb_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(64'h0)) u_d0 (
        .CLK(CLK), .reset(reset), .HTRANS(htrans0), .HADDR(haddr0), .HWRITE(hwrite0),
        .HSIZE(hsize0), .HWDATA(hwdata0), .HRDATA(hrdata0), .HREADYOUT(hready0), .HRESP(hresp0));

    ahb_mem_responder #(.DEPTH(16), .WAIT_CYCLES(3), .BASE_ADDR(64'h0)) u_d3 (
        .CLK(CLK), .reset(reset), .HTRANS(htrans3), .HADDR(haddr3), .HWRITE(hwrite3),
        .HSIZE(hsize3), .HWDATA(hwdata3), .HRDATA(hrdata3), .HREADYOUT(hready3), .HRESP(hresp3));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of bus inputs, then step to just after the next rising edge
    task automatic bus0(input logic t, input logic w, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
        htrans0 = t; hwrite0 = w; hsize0 = sz; haddr0 = a; hwdata0 = d;
        @(posedge CLK); #1;
    endtask

    task automatic bus3(input logic t, input logic w, input logic [1:0] sz, input logic [63:0] a, input logic [63:0] d);
        htrans3 = t; hwrite3 = w; hsize3 = sz; haddr3 = a; hwdata3 = d;
        @(posedge CLK); #1;
    endtask

    initial begin
        htrans0 = 0; hwrite0 = 0; hsize0 = 0; haddr0 = 0; hwdata0 = 0;
        htrans3 = 0; hwrite3 = 0; hsize3 = 0; haddr3 = 0; hwdata3 = 0;
        #12;
        check("rst_rdy", {63'd0, hready0}, 64'd1);
        check("rst_resp", {63'd0, hresp0}, 64'd0);
        check("rst_rdata", hrdata0, 64'd0);
        check("rst_rdy3", {63'd0, hready3}, 64'd1);
        @(posedge CLK); #1;
        reset = 1'b1;

        // zero-wait write then back-to-back read
        bus0(1, 1, 3, 64'h10, 64'd0);
        check("t2_wr_rdy", {63'd0, hready0}, 64'd1);
        bus0(1, 0, 3, 64'h10, 64'h1122334455667788);
        check("t2_rd_data", hrdata0, 64'h1122334455667788);
        check("t2_rd_rdy", {63'd0, hready0}, 64'd1);
        bus0(0, 0, 0, 64'h0, 64'd0);
        check("t2_idle_data", hrdata0, 64'd0);

        // byte and half writes over a zeroed doubleword
        bus0(1, 1, 3, 64'h10, 64'd0);
        bus0(1, 1, 0, 64'h13, 64'd0);
        bus0(1, 0, 3, 64'h10, 64'h00000000AB000000);
        check("t3_byte", hrdata0, 64'h00000000AB000000);
        bus0(1, 1, 1, 64'h16, 64'd0);
        bus0(1, 0, 3, 64'h10, 64'hBEEF000000000000);
        check("t3_half", hrdata0, 64'hBEEF0000AB000000);
        bus0(0, 0, 0, 64'h0, 64'd0);

        // out-of-range read, then misaligned word write, each followed by a good read
        bus0(1, 0, 3, 64'd128, 64'd0);
        check("t5_e1_resp", {63'd0, hresp0}, 64'd1);
        check("t5_e1_rdy", {63'd0, hready0}, 64'd0);
        bus0(1, 0, 3, 64'h10, 64'd0);
        check("t5_e2_resp", {63'd0, hresp0}, 64'd1);
        check("t5_e2_rdy", {63'd0, hready0}, 64'd1);
        check("t5_e2_data", hrdata0, 64'd0);
        bus0(1, 0, 3, 64'h10, 64'd0);
        check("t5_good_resp", {63'd0, hresp0}, 64'd0);
        check("t5_good_data", hrdata0, 64'hBEEF0000AB000000);
        bus0(1, 1, 2, 64'h12, 64'd0);
        check("t5_mis_resp", {63'd0, hresp0}, 64'd1);
        check("t5_mis_rdy", {63'd0, hready0}, 64'd0);
        bus0(1, 0, 3, 64'h10, 64'hFFFFFFFFFFFFFFFF);
        check("t5_mis_e2", {63'd0, hready0}, 64'd1);
        bus0(1, 0, 3, 64'h10, 64'hFFFFFFFFFFFFFFFF);
        check("t5_unchanged", hrdata0, 64'hBEEF0000AB000000);
        bus0(0, 0, 0, 64'h0, 64'd0);

        // alternating reads with an idle cycle between them
        bus0(1, 1, 3, 64'h0, 64'd0);
        bus0(1, 1, 3, 64'h8, 64'hA0A0A0A0A0A0A0A0);
        bus0(1, 0, 3, 64'h0, 64'hB0B0B0B0B0B0B0B0);
        check("t6_rd0", hrdata0, 64'hA0A0A0A0A0A0A0A0);
        bus0(0, 0, 3, 64'h0, 64'd0);
        check("t6_idle", hrdata0, 64'd0);
        bus0(1, 0, 3, 64'h8, 64'd0);
        check("t6_rd8", hrdata0, 64'hB0B0B0B0B0B0B0B0);
        bus0(0, 0, 0, 64'h0, 64'd0);
        check("t6_end", hrdata0, 64'd0);

        // three-wait instance: seed 0x8
        bus3(1, 1, 3, 64'h8, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("seed_wait", {63'd0, hready3}, 64'd0);
            bus3(0, 0, 0, 64'h0, 64'h5555555555555555);
        end
        check("seed_data_rdy", {63'd0, hready3}, 64'd1);
        bus3(0, 0, 0, 64'h0, 64'h5555555555555555);

        // read latency and a second read presented in the completing cycle
        bus3(1, 0, 3, 64'h8, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t4_wait_a", {63'd0, hready3}, 64'd0);
            check("t4_wait_a_data", hrdata3, 64'd0);
            bus3(1, 0, 3, 64'h8, 64'd0);
        end
        check("t4_data_a_rdy", {63'd0, hready3}, 64'd1);
        check("t4_data_a", hrdata3, 64'h5555555555555555);
        bus3(1, 0, 3, 64'h8, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t4_wait_b", {63'd0, hready3}, 64'd0);
            bus3(0, 0, 0, 64'h0, 64'd0);
        end
        check("t4_data_b", hrdata3, 64'h5555555555555555);
        bus3(0, 0, 0, 64'h0, 64'd0);

        // reset during a pending write's wait states drops the write
        bus3(1, 1, 3, 64'h8, 64'd0);
        bus3(0, 0, 0, 64'h0, 64'hDEADDEADDEADDEAD);
        reset = 1'b0;
        #2;
        check("t1_rst_rdy", {63'd0, hready3}, 64'd1);
        check("t1_rst_resp", {63'd0, hresp3}, 64'd0);
        check("t1_rst_data", hrdata3, 64'd0);
        @(posedge CLK); #1;
        reset = 1'b1;
        bus3(1, 0, 3, 64'h8, 64'd0);
        for (int i = 0; i < 3; i++) bus3(0, 0, 0, 64'h0, 64'd0);
        check("t1_kept", hrdata3, 64'h5555555555555555);
        bus3(0, 0, 0, 64'h0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_mem_responder.md
Name: ahb_mem_responder

Overview:
- Memory-side responder for the arbitrated AHB-lite-style bus leaving mem_controller. It completes the transfers that inst_fetch and the data-side initiator start.
- Holds a 64-bit-wide RAM array and decodes single-bit HTRANS requests.
- Returns read data or commits byte-lane writes.
- Inserts a programmable number of wait states through HREADYOUT. mem_controller uses HREADYOUT to drive its stall output.
- Flags out-of-range or misaligned accesses with a two-cycle error response.

Parameters:
- DEPTH, 1024, number of 64-bit doublewords in the array; power of two.
- WAIT_CYCLES, 0, wait states inserted in every OKAY data phase; 0..15.
- BASE_ADDR, 64'h0, byte address of doubleword 0.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- HTRANS  input  1  1 = transfer requested in this address phase.
- HADDR  input  64  byte address, sampled in the address phase.
- HWRITE  input  1  1 = write, 0 = read, sampled in the address phase.
- HSIZE  input  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- HWDATA  input  64  write data, sampled in the final data-phase cycle.
- HRDATA  output  64  read data, valid when HREADYOUT=1 in a read data phase.
- HREADYOUT  output  1  0 = extend the current data phase.
- HRESP  output  1  1 = ERROR response.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0, latched address/control cleared. Array contents are not reset.
- Reset asserted mid-transfer drops the pending transfer; no array write occurs.
- Acceptance: a transfer is accepted at a rising CLK edge when HTRANS=1 and HREADYOUT=1. On acceptance, latch HADDR, HWRITE and HSIZE.
- Offset: off = HADDR - BASE_ADDR. Index = off[3 +: log2(DEPTH)]. Lane = off[2:0].
- Error condition: HADDR < BASE_ADDR, or off >= DEPTH*8, or lane not a multiple of (1<<HSIZE).
- States:
  - IDLE: no data phase outstanding; HREADYOUT=1, HRESP=0. Accept -> ERR1 if error, else WAIT if WAIT_CYCLES>0, else DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter starts at WAIT_CYCLES-1 and decrements each cycle. At 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0.
    - Read: HRDATA = array[index], the full aligned doubleword regardless of HSIZE.
    - Write: HWDATA lanes selected by HSIZE/lane are written to array[index] at the closing edge. Other lanes are unchanged.
    - Next state: a new acceptance in this cycle (pipelined) -> ERR1/WAIT/DATA as in IDLE; otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, no array write, HRDATA=0. Pipelined acceptance allowed as in DATA.
- Latency:
  - Read data appears WAIT_CYCLES+1 cycles after the accepting edge.
  - With WAIT_CYCLES=0, back-to-back transfers complete one per cycle.
- HRDATA is 0 in every cycle that is not a read DATA cycle.
- Read-after-write: a write closing at edge N is visible to a read whose DATA cycle follows edge N. No forwarding logic is required beyond array write-then-read ordering.
- Byte-lane mask for lane L, size S: bytes L .. L+(1<<S)-1.
- HTRANS=0 in an address phase with HREADYOUT=1 is an idle cycle. No state change except DATA/ERR2 -> IDLE.
- Address-phase inputs are ignored while HREADYOUT=0. The initiator must hold them stable; the responder does not check this.

Test Plan:
1. Reset low mid-WAIT (WAIT_CYCLES=2, write to 0x8 pending), then release -> HREADYOUT=1, HRESP=0, HRDATA=0; a later read of 0x8 returns its pre-write value.
2. WAIT_CYCLES=0: write dword 0x1122334455667788 @0x10, then read 0x10 next cycle -> HRDATA=0x1122334455667788 one cycle after the read is accepted; HREADYOUT stays 1 throughout.
3. Byte write 0xAB @0x13 over 0 -> read 0x10 returns 0x00000000AB000000. Half write 0xBEEF @0x16 -> read 0x10 returns 0xBEEF0000AB000000.
4. WAIT_CYCLES=3, read accepted at cycle 0 -> HREADYOUT=0 in cycles 1-3, =1 with valid data in cycle 4. A second read presented in cycle 4 is accepted and stalls for cycles 5-7.
5. Read @DEPTH*8, or word access @0x2 -> cycle 1: HRESP=1, HREADYOUT=0; cycle 2: HRESP=1, HREADYOUT=1; array unchanged. A following good read completes normally.
6. Alternating reads @0x0 and @0x8 with HTRANS toggled 1,0,1 -> correct data each time; the HTRANS=0 cycle returns the state to IDLE with HRDATA=0.
